qei_input_ctrl: RTL

QEI_INPUT_CTRL -- requirements
Module: qei_input_ctrl

---
 rtl/qei_input_ctrl_if.sv | 14 +
 rtl/qei_input_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/qei_input_ctrl_if.sv
// qei_input_ctrl_if: CPU request/acknowledge channel of the QEI input controller.
// Ports: req (CPU -> ctrl, level held until ack), ack (one-cycle pulse),
//        data (committed value, valid with ack), busy (controller not idle).
interface qei_input_ctrl_if #(
  parameter int BIT_WIDTH = 8
);
  logic                 req;
  logic                 ack;
  logic [BIT_WIDTH-1:0] data;
  logic                 busy;

  modport master (output req, input ack, input data, input busy);
  modport slave  (input req, output ack, output data, output busy);
endinterface

// File: rtl/qei_input_ctrl.sv
// qei_input_ctrl: turns a quadrature-counter value into a CPU-requested, button-committed input.
// Latency: enc_count reaches sel_value in 4 clk; with a clean button, ack follows a press by 3 clk.
// Backpressure: none. The CPU holds req until ack, and ack is not repeated until req falls.
// Ports: clk, nrst (async active-low); cpu (req/ack/data/busy, slave modport);
//        enc_count, btn (asynchronous inputs); sel_value (live preview);
//        qei_nrst, div_ratio (to the counter); cfg_we/cfg_data (ratio write, IDLE only).
// Build option: define QEI_CTRL_DEBOUNCE_EN to add the DEBOUNCE_CYCLES button filter.
module qei_input_ctrl #(
  parameter int BIT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CLR_CYCLES      = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  qei_input_ctrl_if.slave      cpu,
  input  logic [BIT_WIDTH-1:0] enc_count,
  input  logic                 btn,
  output logic [BIT_WIDTH-1:0] sel_value,
  output logic                 qei_nrst,
  output logic [BIT_WIDTH-1:0] div_ratio,
  input  logic                 cfg_we,
  input  logic [BIT_WIDTH-1:0] cfg_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_SELECT   = 3'd2;
  localparam logic [2:0] S_ACK      = 3'd3;
  localparam logic [2:0] S_WAIT_LOW = 3'd4;

  localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  // ---------------------------------------------------------------
  // enc_count synchronizer. The bus is multi-bit, so a sample taken
  // mid-transition can be skewed; stable_count only follows after two
  // consecutive synchronized samples agree.
  // ---------------------------------------------------------------
  logic [BIT_WIDTH-1:0] cnt_s1_q, cnt_s2_q, cnt_s3_q, stable_q;
  logic [BIT_WIDTH-1:0] stable_d;

  always_comb begin
    stable_d = stable_q;
    if (cnt_s2_q == cnt_s3_q) stable_d = cnt_s3_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_s1_q <= '0;
      cnt_s2_q <= '0;
      cnt_s3_q <= '0;
      stable_q <= '0;
    end else begin
      cnt_s1_q <= enc_count;
      cnt_s2_q <= cnt_s1_q;
      cnt_s3_q <= cnt_s2_q;
      stable_q <= stable_d;
    end
  end

  assign sel_value = stable_q;

  // ---------------------------------------------------------------
  // Button synchronizer and optional debounce filter
  // ---------------------------------------------------------------
  logic btn_s1_q, btn_s2_q;
  logic btn_acc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
    end
  end

`ifdef QEI_CTRL_DEBOUNCE_EN
  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            btn_acc_q, btn_acc_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // db_cnt counts consecutive samples that differ from the accepted level;
  // any sample matching the accepted level restarts the count.
  always_comb begin
    btn_acc_d = btn_acc_q;
    db_cnt_d  = '0;
    if (btn_s2_q != btn_acc_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_acc_d = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_acc_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      btn_acc_q <= btn_acc_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign btn_acc = btn_acc_q;
`else
  assign btn_acc = btn_s2_q;

  // DEBOUNCE_CYCLES has no role without the filter.
  if (DEBOUNCE_CYCLES < 0) begin : g_db_unused
  end
`endif

  // ---------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------
  logic [2:0]           state_q, state_d;
  logic                 qei_nrst_q, qei_nrst_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic                 armed_q, armed_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic [BIT_WIDTH-1:0] div_q, div_d;

  always_comb begin
    state_d    = state_q;
    qei_nrst_d = qei_nrst_q;
    clr_cnt_d  = clr_cnt_q;
    armed_d    = armed_q;
    data_d     = data_q;
    div_d      = div_q;

    case (state_q)
      S_IDLE: begin
        qei_nrst_d = 1'b1;
        if (cfg_we) div_d = cfg_data;
        if (cpu.req) begin
          state_d    = S_CLEAR;
          qei_nrst_d = 1'b0;
          clr_cnt_d  = '0;
        end
      end
      S_CLEAR: begin
        if (!cpu.req) begin
          state_d    = S_IDLE;
          qei_nrst_d = 1'b1;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d    = S_SELECT;
          qei_nrst_d = 1'b1;
          // A button already held on entry must be released before it can commit.
          armed_d    = ~btn_acc;
        end else begin
          clr_cnt_d  = clr_cnt_q + 1'b1;
        end
      end
      S_SELECT: begin
        // Abort takes priority over a commit in the same cycle.
        if (!cpu.req) begin
          state_d = S_IDLE;
        end else if (armed_q && btn_acc) begin
          state_d = S_ACK;
          data_d  = stable_q;
        end else if (!btn_acc) begin
          armed_d = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!cpu.req) state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        qei_nrst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      qei_nrst_q <= 1'b0;
      clr_cnt_q  <= '0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      qei_nrst_q <= qei_nrst_d;
      clr_cnt_q  <= clr_cnt_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      div_q      <= div_d;
    end
  end

  // ack is decoded from state so an asynchronous reset clears it at once.
  assign cpu.ack   = (state_q == S_ACK);
  assign cpu.busy  = (state_q != S_IDLE);
  assign cpu.data  = data_q;
  assign qei_nrst  = qei_nrst_q;
  assign div_ratio = div_q;

endmodule
